// File: rtl/rxstr_pkg.sv
// rtl/rxstr_pkg.sv - shared baud constants and message helper for the rxstr receiver
package rxstr_pkg;

  // Clock cycles per serial bit with a 12 MHz system clock
  localparam int B115200 = 104;
  localparam int B57600  = 208;
  localparam int B9600   = 1250;

  // Longest message the matcher can track, and its packed width
  localparam int MSG_MAX_LEN  = 16;
  localparam int MSG_MAX_BITS = 8 * MSG_MAX_LEN;

  // Byte i of a message of len bytes, first character in the most significant
  // byte, right-aligned inside msg; indices past the end read as zero
  function automatic logic [7:0] msg_byte(input logic [MSG_MAX_BITS-1:0] msg,
                                          input int len,
                                          input logic [3:0] i);
    int sh;
    if (int'(i) >= len) return 8'h00;
    sh = 8 * (len - 1 - int'(i));
    return msg[sh +: 8];
  endfunction

endpackage

// File: rtl/rxstr_rxbyte.sv
// rtl/rxstr_rxbyte.sv - 8N1 byte receiver: synchroniser, baud counter and framing FSM
module rxbyte
  import rxstr_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       ferr,
  output logic [7:0] pre_data,
  output logic       pre_rcv,
  output logic       pre_ferr
);

  localparam int            CW        = $clog2(BAUD);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_rcv;
  logic          r_ferr;
  logic          w_half;
  logic          w_full;

  assign w_half = (r_cnt == HALF_LAST);
  assign w_full = (r_cnt == FULL_LAST);

  // The pre_* signals mark the stop-sample cycle so the matcher can register
  // its result in the same cycle that rcv/data become visible
  assign pre_rcv  = (r_state == S_STOP) && w_full && r_s2;
  assign pre_ferr = (r_state == S_STOP) && w_full && !r_s2;
  assign pre_data = r_shift;

  assign data = r_data;
  assign rcv  = r_rcv;
  assign ferr = r_ferr;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= rx;
      r_s2 <= r_s1;
    end
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state: start bit is re-checked mid-bit to reject glitches
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!r_s2) w_next = S_START;
      S_START: if (w_half) w_next = r_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (w_full && (r_bit == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_full) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Baud counter restarts on every state entry and after each full bit time
  always_ff @(posedge clk) begin
    if (!rstn)
      r_cnt <= '0;
    else if ((r_state == S_IDLE) || (w_next != r_state) || w_full)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  // Data bits arrive LSB first, so shift in from the top
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
    end else if (r_state == S_START) begin
      r_bit <= 3'd0;
    end else if ((r_state == S_DATA) && w_full) begin
      r_shift <= {r_s2, r_shift[7:1]};
      r_bit   <= r_bit + 3'd1;
    end
  end

  // Output byte and one-cycle strobes; a bad stop bit keeps the old byte
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_data <= 8'h00;
      r_rcv  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_rcv  <= pre_rcv;
      r_ferr <= pre_ferr;
      if (pre_rcv) r_data <= r_shift;
    end
  end

endmodule

// File: rtl/rxstr.sv
// rtl/rxstr.sv - serial string receiver that pulses match when the message arrives in order
module rxstr
  import rxstr_pkg::*;
#(
  parameter int             BAUD = B115200,
  parameter int             LEN  = 5,
  parameter logic [8*LEN-1:0] MSG  = "Hola!"
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       ferr,
  output logic       match,
  output logic [3:0] idx
);

  localparam logic [MSG_MAX_BITS-1:0] MSG_W = MSG_MAX_BITS'(MSG);
  localparam logic [3:0]              LAST  = 4'(LEN - 1);

  logic [7:0] w_data;
  logic       w_rcv;
  logic       w_ferr;
  logic [7:0] w_pre_data;
  logic       w_pre_rcv;
  logic       w_pre_ferr;
  logic [7:0] w_want;
  logic [7:0] w_first;
  logic [3:0] r_idx;
  logic       r_match;

  rxbyte #(
    .BAUD(BAUD)
  ) u_rxbyte (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (rx),
    .data     (w_data),
    .rcv      (w_rcv),
    .ferr     (w_ferr),
    .pre_data (w_pre_data),
    .pre_rcv  (w_pre_rcv),
    .pre_ferr (w_pre_ferr)
  );

  assign w_want  = msg_byte(MSG_W, LEN, r_idx);
  assign w_first = msg_byte(MSG_W, LEN, 4'd0);

  assign data  = w_data;
  assign rcv   = w_rcv;
  assign ferr  = w_ferr;
  assign match = r_match;
  assign idx   = r_idx;

  // Matcher: advance on the expected byte, restart on the first byte,
  // otherwise fall back to zero; a framing error also clears progress
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_idx   <= 4'd0;
      r_match <= 1'b0;
    end else begin
      r_match <= 1'b0;
      if (w_pre_ferr) begin
        r_idx <= 4'd0;
      end else if (w_pre_rcv) begin
        if (w_pre_data == w_want) begin
          if (r_idx == LAST) begin
            r_match <= 1'b1;
            r_idx   <= 4'd0;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end else if (w_pre_data == w_first) begin
          if (LEN == 1) begin
            r_match <= 1'b1;
            r_idx   <= 4'd0;
          end else begin
            r_idx <= 4'd1;
          end
        end else begin
          r_idx <= 4'd0;
        end
      end
    end
  end

endmodule
